cpu_debug_ctrl: RTL and testbench
=================================

Name: cpu_debug_ctrl

Overview:
- Host-side debug and run controller for the 8-bit multicycle CPU.
- Gates advance of the CPU FSM state register (`cpu_en`) and issues CPU resets.
- Takes over the shared program/data memory port when the CPU is stopped.
- Executes host commands (memory load/readback, run, halt, single-step) through a valid/ready command channel and a pulsed response channel.
- Sits between the host/loader and the CPU top; the control unit and datapath are unchanged.

Parameters:
- ADDR_W, 4, memory address width (16 bytes, matching the 4-bit pc/addr offsets).
- DATA_W, 8, memory/instruction data width.
- RST_CYCLES, 2, number of cycles `cpu_rst` is held for a CPU_RST command (≥1).
- STEP_TIMEOUT, 16, maximum cycles a STEP may take before it is aborted with an error (≥6).
- BOOT_RUN, 0, 1 = enter RUN on the first cycle after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset; one clock; sampled on the rising edge of clk
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller can accept a command; depends on state only
- cmd_op  in  3  0 NOP, 1 MEM_WR, 2 MEM_RD, 3 RUN, 4 HALT, 5 STEP, 6 CPU_RST, 7 reserved
- cmd_addr  in  ADDR_W  memory address for MEM_WR/MEM_RD
- cmd_wdata  in  DATA_W  write data for MEM_WR
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_err  out  1  command rejected or aborted; qualified by rsp_valid
- rsp_data  out  DATA_W  MEM_RD data, else 0
- cpu_state  in  3  current CPU FSM state (FETCH=0 … HALT_STATE=5)
- cpu_halt  in  1  control unit halt output
- cpu_en  out  1  CPU state register and write enables may advance this cycle
- cpu_rst  out  1  synchronous reset to the CPU (PC, IR, A, B, ZF, state)
- dbg_mem_sel  out  1  memory port owned by controller
- dbg_addr  out  ADDR_W  memory address when dbg_mem_sel=1
- dbg_wdata  out  DATA_W  memory write data
- dbg_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  synchronous-read memory data (1-cycle latency)
- running  out  1  controller in RUN or STEP

Behaviour:
- Controller states: IDLE, RUN, STEP, MEM_WR, MEM_RD0, MEM_RD1, CRST.
- Reset:
  - Next state is IDLE, or RUN when BOOT_RUN=1.
  - All outputs are 0 during reset, including cmd_ready.
  - The step and reset counters clear.
  - Reset mid-operation aborts any command with no response.
- Handshake:
  - A transfer occurs when cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE and RUN.
  - Every accepted command except NOP produces exactly one rsp_valid pulse.
- IDLE: cpu_en=0 and dbg_mem_sel=0.
- MEM_WR accepted in cycle N:
  - In N+1: dbg_mem_sel=1, dbg_we=1, with cmd address/data registered.
  - rsp_valid pulses in N+1, then return to IDLE.
- MEM_RD accepted in cycle N:
  - In N+1: dbg_mem_sel=1, dbg_addr driven.
  - In N+2: rsp_valid=1 with rsp_data=mem_rdata, then return to IDLE.
- RUN accepted in IDLE:
  - Error if cpu_halt=1.
  - Otherwise rsp_valid next cycle and enter RUN; cpu_en=1 from that cycle.
- In RUN:
  - If cpu_halt=1: cpu_en=0 in the same cycle (combinational), go to IDLE, no response.
  - HALT accepted in RUN sets halt_pending. While halt_pending, cpu_en = (cpu_state != FETCH). On the first cycle with cpu_state==FETCH, go to IDLE and pulse rsp_valid. The CPU therefore always stops at an instruction boundary.
  - RUN accepted in RUN: acknowledge, no-op.
  - MEM_WR, MEM_RD, STEP or CPU_RST accepted in RUN: rsp_err=1 next cycle, no action.
- HALT accepted in IDLE: immediate acknowledge next cycle.
- STEP accepted in IDLE:
  - Error if cpu_halt=1.
  - Otherwise enter STEP with the left_fetch flag clear and step counter=0.
  - cpu_en=1 except when cpu_state==FETCH and left_fetch=1.
  - left_fetch sets on the first cycle with cpu_state!=FETCH.
  - Completion with rsp_valid, back to IDLE: cpu_state==FETCH && left_fetch, or cpu_halt=1 (no error).
  - If the step counter reaches STEP_TIMEOUT first: cpu_en=0, rsp_err=1, back to IDLE.
- CPU_RST accepted in IDLE:
  - cpu_rst=1 for exactly RST_CYCLES cycles starting N+1.
  - rsp_valid in the cycle after the last cpu_rst cycle.
  - Return to IDLE with the CPU stopped.
- Opcode 7: rsp_err next cycle.
- Invariants:
  - dbg_mem_sel=1 implies cpu_en=0.
  - cpu_en=0 whenever cpu_rst=1.
  - rsp_err=0 and rsp_data=0 whenever rsp_valid=0.

Decomposition:
- Shared package cpu_pkg holds:
  - CPU FSM state constants (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT_STATE), which the control unit also uses.
  - Debug opcode constants.
  - Controller state encoding.
- Single module; the shared down-counter for CRST and the STEP timeout stays inline, with no sub-module.

Test Plan:
- MEM_WR addr=3 data=8'hA5, then MEM_RD addr=3 → dbg_we pulses once at addr 3; read rsp_data=8'hA5 two cycles after accept, rsp_err=0.
- STEP with the CPU model cycling FETCH→DECODE→EXECUTE→FETCH → cpu_en high for 3 cycles; rsp_valid when the state returns to FETCH; running=0 afterwards.
- RUN, then HALT issued while cpu_state=EXECUTE → response only once cpu_state=FETCH, cpu_en=0 from that cycle; MEM_RD issued in RUN → rsp_err=1.
- cpu_halt asserted in RUN → cpu_en drops the same cycle, controller in IDLE; a subsequent STEP or RUN → rsp_err=1.
- STEP with cpu_state stuck at DECODE → rsp_err=1 after 16 cycles; CPU_RST → cpu_rst high exactly 2 cycles, then rsp_valid.
- Assert reset during MEM_RD0 → no response; all outputs 0 the following cycle; cmd_ready=1 the cycle after reset deasserts (BOOT_RUN=0).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-unit FSM state codes, debug opcodes and
// the debug controller's own state encoding.
package cpu_pkg;

  localparam logic [2:0] FETCH      = 3'd0;
  localparam logic [2:0] DECODE     = 3'd1;
  localparam logic [2:0] EXECUTE    = 3'd2;
  localparam logic [2:0] MEMORY     = 3'd3;
  localparam logic [2:0] WRITEBACK  = 3'd4;
  localparam logic [2:0] HALT_STATE = 3'd5;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_MEM_WR  = 3'd1,
    OP_MEM_RD  = 3'd2,
    OP_RUN     = 3'd3,
    OP_HALT    = 3'd4,
    OP_STEP    = 3'd5,
    OP_CPU_RST = 3'd6,
    OP_RSVD    = 3'd7
  } dbg_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_MEM_WR, S_MEM_RD0, S_MEM_RD1, S_CRST
  } dbg_state_e;

  // response scheduled for the cycle after a command is accepted
  typedef struct packed {
    logic vld;
    logic err;
  } rsp_t;

endpackage

// File: rtl/cpu_debug_ctrl.sv
// Host debug/run controller: gates CPU advance, issues CPU resets and owns
// the shared memory port while the CPU is stopped.
module cpu_debug_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int RST_CYCLES   = 2,
  parameter int STEP_TIMEOUT = 16,
  parameter int BOOT_RUN     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [2:0]        cpu_state,
  input  logic              cpu_halt,
  output logic              cpu_en,
  output logic              cpu_rst,
  output logic              dbg_mem_sel,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              running
);

  localparam int CNT_MAX = (STEP_TIMEOUT > RST_CYCLES) ? STEP_TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  dbg_state_e        state, state_nx;
  logic              halt_pend, halt_pend_nx;
  logic              left_fetch, left_fetch_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  rsp_t              rq, rq_nx;

  dbg_op_e           op;
  logic              rdy, acc, at_fetch;
  logic              en, rst_c, sel, we, vld, err;
  logic [DATA_W-1:0] rdata;

  assign op       = dbg_op_e'(cmd_op);
  assign at_fetch = (cpu_state == FETCH);
  // a pending HALT owns the response slot until the CPU reaches FETCH
  assign rdy      = (state == S_IDLE) | ((state == S_RUN) & ~halt_pend);
  assign acc      = cmd_valid & rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= (BOOT_RUN != 0) ? S_RUN : S_IDLE;
      halt_pend  <= 1'b0;
      left_fetch <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rq         <= '0;
    end else begin
      state      <= state_nx;
      halt_pend  <= halt_pend_nx;
      left_fetch <= left_fetch_nx;
      cnt        <= cnt_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      rq         <= rq_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    halt_pend_nx  = halt_pend;
    left_fetch_nx = left_fetch;
    cnt_nx        = cnt;
    addr_nx       = addr_q;
    wdata_nx      = wdata_q;
    rq_nx         = '0;
    en            = 1'b0;
    rst_c         = 1'b0;
    sel           = 1'b0;
    we            = 1'b0;
    vld           = rq.vld;
    err           = rq.err;
    rdata         = '0;
    case (state)
      S_IDLE: begin
        if (acc) begin
          case (op)
            OP_NOP: ;
            OP_MEM_WR: begin
              addr_nx  = cmd_addr;
              wdata_nx = cmd_wdata;
              state_nx = S_MEM_WR;
            end
            OP_MEM_RD: begin
              addr_nx  = cmd_addr;
              state_nx = S_MEM_RD0;
            end
            OP_RUN: begin
              rq_nx = '{vld: 1'b1, err: cpu_halt};
              if (!cpu_halt) begin
                state_nx     = S_RUN;
                halt_pend_nx = 1'b0;
              end
            end
            OP_HALT: rq_nx = '{vld: 1'b1, err: 1'b0};
            OP_STEP: begin
              if (cpu_halt) rq_nx = '{vld: 1'b1, err: 1'b1};
              else begin
                state_nx      = S_STEP;
                left_fetch_nx = 1'b0;
                cnt_nx        = CNT_W'(STEP_TIMEOUT);
              end
            end
            OP_CPU_RST: begin
              state_nx = S_CRST;
              cnt_nx   = CNT_W'(RST_CYCLES - 1);
            end
            default: rq_nx = '{vld: 1'b1, err: 1'b1};
          endcase
        end
      end
      S_RUN: begin
        en = ~cpu_halt & ~(halt_pend & at_fetch);
        if (acc) begin
          case (op)
            OP_NOP:  ;
            OP_RUN:  rq_nx = '{vld: 1'b1, err: 1'b0};
            // a CPU that halts in the same cycle is already stopped
            OP_HALT: if (cpu_halt) rq_nx = '{vld: 1'b1, err: 1'b0};
                     else halt_pend_nx = 1'b1;
            default: rq_nx = '{vld: 1'b1, err: 1'b1};
          endcase
        end
        if (halt_pend & (at_fetch | cpu_halt)) begin
          vld          = 1'b1;
          err          = 1'b0;
          halt_pend_nx = 1'b0;
          state_nx     = S_IDLE;
        end else if (cpu_halt) begin
          state_nx = S_IDLE;
        end
      end
      S_STEP: begin
        if ((at_fetch & left_fetch) | cpu_halt) begin
          vld      = 1'b1;
          err      = 1'b0;
          state_nx = S_IDLE;
        end else if (cnt == '0) begin
          vld      = 1'b1;
          err      = 1'b1;
          state_nx = S_IDLE;
        end else begin
          en     = 1'b1;
          cnt_nx = cnt - CNT_W'(1);
          if (!at_fetch) left_fetch_nx = 1'b1;
        end
      end
      S_MEM_WR: begin
        sel      = 1'b1;
        we       = 1'b1;
        vld      = 1'b1;
        err      = 1'b0;
        state_nx = S_IDLE;
      end
      S_MEM_RD0: begin
        sel      = 1'b1;
        state_nx = S_MEM_RD1;
      end
      S_MEM_RD1: begin
        sel      = 1'b1;
        vld      = 1'b1;
        err      = 1'b0;
        rdata    = mem_rdata;
        state_nx = S_IDLE;
      end
      S_CRST: begin
        rst_c = 1'b1;
        if (cnt == '0) begin
          rq_nx    = '{vld: 1'b1, err: 1'b0};
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // every output is forced low while reset is sampled
  assign cmd_ready   = rdy & ~reset;
  assign rsp_valid   = vld & ~reset;
  assign rsp_err     = vld & err & ~reset;
  assign rsp_data    = (vld & ~reset) ? rdata : '0;
  assign cpu_en      = en & ~reset;
  assign cpu_rst     = rst_c & ~reset;
  assign dbg_mem_sel = sel & ~reset;
  assign dbg_we      = we & ~reset;
  assign dbg_addr    = (sel & ~reset) ? addr_q : '0;
  assign dbg_wdata   = (we & ~reset) ? wdata_q : '0;
  assign running     = ((state == S_RUN) | (state == S_STEP)) & ~reset;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: CPU/memory environment models plus a
// transaction-level reference of expected response latency/err/data.
module tb_cpu_debug_ctrl;
  import cpu_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RC = 2;
  localparam int ST = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cmd_valid, cmd_ready, rsp_valid, rsp_err;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr, dbg_addr;
  logic [DW-1:0] cmd_wdata, rsp_data, dbg_wdata, mem_rdata;
  logic          cpu_halt, cpu_en, cpu_rst, dbg_mem_sel, dbg_we, running;
  logic [2:0]    cpu_state = FETCH;

  int n_cmp = 0;
  int n_err = 0;

  logic          stuck = 1'b0;
  logic          set_req = 1'b0;
  logic [2:0]    set_val = FETCH;
  int            instr_len = 3;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];

  cpu_debug_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RST_CYCLES(RC),
                   .STEP_TIMEOUT(ST), .BOOT_RUN(0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .cpu_state(cpu_state), .cpu_halt(cpu_halt), .cpu_en(cpu_en),
    .cpu_rst(cpu_rst), .dbg_mem_sel(dbg_mem_sel), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_we(dbg_we), .mem_rdata(mem_rdata),
    .running(running));

  // CPU model: an instruction is instr_len states long (3..5)
  function automatic logic [2:0] next_st(input logic [2:0] s);
    case (s)
      FETCH:   return DECODE;
      DECODE:  return EXECUTE;
      EXECUTE: return (instr_len > 3) ? MEMORY : FETCH;
      MEMORY:  return (instr_len > 4) ? WRITEBACK : FETCH;
      default: return FETCH;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cpu_rst) cpu_state <= FETCH;
    else if (set_req) cpu_state <= set_val;
    else if (cpu_en && !stuck && cpu_state != HALT_STATE) cpu_state <= next_st(cpu_state);
  end

  // environment memory clears on reset; sync read
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (dbg_we) mem[dbg_addr] <= dbg_wdata;
    mem_rdata <= mem[dbg_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({cmd_ready, rsp_valid, rsp_err, rsp_data, cpu_en, cpu_rst,
                dbg_mem_sel, dbg_addr, dbg_wdata, dbg_we, running});
  endfunction

  always @(posedge clk) begin
    #2;
    chk("invariant", 32'((dbg_mem_sel & cpu_en) | (cpu_rst & cpu_en) |
                         (~rsp_valid & (rsp_err | (|rsp_data)))), 32'd0);
  end

  // entered at a negedge; returns at the negedge of the cycle after accept
  task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
    chk("accept", 32'(n < 40), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  task automatic wait_rsp(input int max, output int lat, output logic e, output logic [DW-1:0] d,
                          output int en_c, output int rst_c);
    lat = 0; e = 1'b0; d = '0; en_c = 0; rst_c = 0;
    for (int k = 1; k <= max; k++) begin
      if (cpu_en) en_c++;
      if (cpu_rst) rst_c++;
      if (rsp_valid) begin lat = k; e = rsp_err; d = rsp_data; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int e_lat, input logic e_err,
                         input logic [DW-1:0] e_data, input int e_en, input int e_rst);
    int lat, en_c, rst_c;
    logic e;
    logic [DW-1:0] rd;
    send(op, a, d);
    wait_rsp((e_lat == 0) ? 4 : e_lat + 3, lat, e, rd, en_c, rst_c);
    chk({tag, "_lat"}, lat, e_lat);
    if (e_lat != 0) begin
      chk({tag, "_err"}, 32'(e), 32'(e_err));
      chk({tag, "_data"}, 32'(rd), 32'(e_data));
    end
    chk({tag, "_en"}, en_c, e_en);
    chk({tag, "_rst"}, rst_c, e_rst);
  endtask

  task automatic set_cpu(input logic [2:0] s);
    set_val = s; set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int r, n, found;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = '0; cmd_wdata = '0;
    cpu_halt = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    @(negedge clk);
    chk("rst_outs", outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 32'h0800_0000);

    // write then read back one byte
    send(OP_MEM_WR, 4'd3, 8'hA5);
    ref_mem[3] = 8'hA5;
    chk("wr_we", 32'(dbg_we), 32'd1);
    chk("wr_sel", 32'(dbg_mem_sel), 32'd1);
    chk("wr_addr", 32'(dbg_addr), 32'd3);
    chk("wr_data", 32'(dbg_wdata), 32'hA5);
    chk("wr_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
    @(negedge clk);
    chk("wr_we_once", 32'(dbg_we), 32'd0);
    send(OP_MEM_RD, 4'd3, 8'h00);
    chk("rd0_sel", 32'({dbg_mem_sel, dbg_addr}), 32'h13);
    chk("rd0_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd1_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'h2A5);
    @(negedge clk);

    // random idle-mode traffic
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      a = AW'($urandom_range(0, 15));
      d = DW'($urandom);
      if (r == 0) run_cmd("nop", OP_NOP, a, d, 0, 1'b0, 8'h00, 0, 0);
      else if (r <= 3) begin
        run_cmd("mwr", OP_MEM_WR, a, d, 1, 1'b0, 8'h00, 0, 0);
        ref_mem[a] = d;
      end
      else if (r <= 6) run_cmd("mrd", OP_MEM_RD, a, d, 2, 1'b0, ref_mem[a], 0, 0);
      else if (r == 7) run_cmd("ihalt", OP_HALT, a, d, 1, 1'b0, 8'h00, 0, 0);
      else if (r == 8) run_cmd("rsvd", OP_RSVD, a, d, 1, 1'b1, 8'h00, 0, 0);
      else if ($urandom_range(0, 1) == 1) begin
        instr_len = $urandom_range(3, 5);
        run_cmd("step", OP_STEP, a, d, instr_len + 1, 1'b0, 8'h00, instr_len, 0);
        chk("step_run", 32'(running), 32'd0);
        chk("step_fetch", 32'(cpu_state), 32'(FETCH));
      end else
        run_cmd("crst_r", OP_CPU_RST, a, d, RC + 1, 1'b0, 8'h00, 0, RC);
    end

    // RUN, rejected/acked commands in RUN, then HALT at EXECUTE
    instr_len = 5;
    run_cmd("run_go", OP_RUN, 4'd0, 8'd0, 1, 1'b0, 8'h00, 1, 0);
    chk("run_running", 32'(running), 32'd1);
    repeat ($urandom_range(1, 6)) @(negedge clk);
    run_cmd("run_rd", OP_MEM_RD, 4'd3, 8'd0, 1, 1'b1, 8'h00, 1, 0);
    run_cmd("run_run", OP_RUN, 4'd0, 8'd0, 1, 1'b0, 8'h00, 1, 0);
    run_cmd("run_crst", OP_CPU_RST, 4'd0, 8'd0, 1, 1'b1, 8'h00, 1, 0);
    n = 0;
    while (cpu_state != EXECUTE && n < 20) begin @(negedge clk); n++; end
    chk("exec_seen", 32'(n < 20), 32'd1);
    send(OP_HALT, 4'd0, 8'd0);
    chk("halt_st1", 32'(cpu_state), 32'(MEMORY));
    found = 0;
    for (int k = 1; k <= 10; k++) begin
      if (cpu_state == FETCH) begin
        chk("halt_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
        chk("halt_en", 32'(cpu_en), 32'd0);
        chk("halt_lat", k, instr_len - 2);
        found = 1;
        break;
      end
      chk("halt_wait_rsp", 32'(rsp_valid), 32'd0);
      chk("halt_wait_en", 32'(cpu_en), 32'd1);
      @(negedge clk);
    end
    chk("halt_found", found, 1);
    @(negedge clk);
    chk("halt_idle", 32'({running, cmd_ready, cpu_en}), 32'b010);
    repeat (3) @(negedge clk);
    chk("halt_stay", 32'(cpu_state), 32'(FETCH));

    // CPU halts on its own while running
    instr_len = 3;
    run_cmd("run_go2", OP_RUN, 4'd0, 8'd0, 1, 1'b0, 8'h00, 1, 0);
    repeat (2) @(negedge clk);
    cpu_halt = 1'b1;
    #1;
    chk("chalt_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    chk("chalt_idle", 32'({running, cmd_ready, rsp_valid}), 32'b010);
    run_cmd("chalt_step", OP_STEP, 4'd0, 8'd0, 1, 1'b1, 8'h00, 0, 0);
    run_cmd("chalt_run", OP_RUN, 4'd0, 8'd0, 1, 1'b1, 8'h00, 0, 0);
    cpu_halt = 1'b0;
    set_cpu(FETCH);

    // STEP that never completes an instruction
    stuck = 1'b1;
    set_cpu(DECODE);
    run_cmd("step_to", OP_STEP, 4'd0, 8'd0, ST + 1, 1'b1, 8'h00, ST, 0);
    chk("step_to_run", 32'(running), 32'd0);
    stuck = 1'b0;

    // CPU reset from a mid-instruction state
    set_cpu(EXECUTE);
    run_cmd("crst", OP_CPU_RST, 4'd0, 8'd0, RC + 1, 1'b0, 8'h00, 0, RC);
    chk("crst_fetch", 32'(cpu_state), 32'(FETCH));

    // reset while a read is in flight
    send(OP_MEM_RD, 4'd5, 8'd0);
    chk("rrd_sel", 32'(dbg_mem_sel), 32'd1);
    reset = 1'b1;
    #1;
    chk("rrd_outs0", outs(), 32'd0);
    @(negedge clk);
    chk("rrd_outs1", outs(), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    chk("rrd_idle", outs(), 32'h0800_0000);
    @(negedge clk);
    chk("rrd_norsp", 32'(rsp_valid), 32'd0);
    d = DW'($urandom);
    run_cmd("post_wr", OP_MEM_WR, 4'd9, d, 1, 1'b0, 8'h00, 0, 0);
    ref_mem[9] = d;
    run_cmd("post_rd", OP_MEM_RD, 4'd9, 8'd0, 2, 1'b0, ref_mem[9], 0, 0);
    run_cmd("post_rd0", OP_MEM_RD, 4'd5, 8'd0, 2, 1'b0, ref_mem[5], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
